// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin scheduler placing six FU results onto two registered CDBs.
// Ports: clock/reset, per-source req_* bundles with req_ready, squash_thread0/1, cdb1_*/cdb2_*.
module cdb_arbiter #(
  parameter int NUM_REQ  = 6,
  parameter int PRF_SIZE = 64,
  parameter int ROB_SIZE = 32,
  parameter int DATA_W   = 64,
  localparam int TW = $clog2(PRF_SIZE),
  localparam int RW = $clog2(ROB_SIZE) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TW-1:0] req_tag,
  input  logic [NUM_REQ*RW-1:0] req_rob_idx,
  input  logic [NUM_REQ-1:0]    req_branch_taken,
  input  logic [NUM_REQ-1:0]    req_thread,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  squash_thread0,
  input  logic                  squash_thread1,
  output logic                  cdb1_valid,
  output logic                  cdb2_valid,
  output logic [TW-1:0]         cdb1_tag,
  output logic [TW-1:0]         cdb2_tag,
  output logic [DATA_W-1:0]     cdb1_out,
  output logic [DATA_W-1:0]     cdb2_out,
  output logic [RW-1:0]         cdb1_rob_idx,
  output logic [RW-1:0]         cdb2_rob_idx,
  output logic                  cdb1_branch_is_taken,
  output logic                  cdb2_branch_is_taken,
  output logic                  cdb1_thread,
  output logic                  cdb2_thread,
  output logic [2:0]            cdb1_src,
  output logic [2:0]            cdb2_src
);

  logic [NUM_REQ-1:0] slot_valid;
  logic [DATA_W-1:0]  slot_data  [NUM_REQ];
  logic [TW-1:0]      slot_tag   [NUM_REQ];
  logic [RW-1:0]      slot_rob   [NUM_REQ];
  logic [NUM_REQ-1:0] slot_taken;
  logic [NUM_REQ-1:0] slot_thread;

  logic [2:0] rr_ptr;

  logic [NUM_REQ-1:0] kill;
  logic [NUM_REQ-1:0] in_kill;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;

  logic       g1_v;
  logic       g2_v;
  logic [2:0] g1;
  logic [2:0] g2;
  logic [2:0] last;
  logic [3:0] sum;
  logic [3:0] idx;

  // A slot (or incoming result) is flushed when its own thread is squashed.
  always_comb begin
    kill    = '0;
    in_kill = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      kill[i] = slot_thread[i] ? squash_thread1
                               : squash_thread0;
      in_kill[i] = req_thread[i] ? squash_thread1
                                 : squash_thread0;
    end
  end

  assign elig = slot_valid & ~kill;

  // Circular scan from rr_ptr; first hit takes CDB1, second CDB2.
  always_comb begin
    g1_v = 1'b0;
    g2_v = 1'b0;
    g1   = '0;
    g2   = '0;
    sum  = '0;
    idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      idx = (sum >= 4'(NUM_REQ)) ? sum - 4'(NUM_REQ)
                                 : sum;
      if (elig[idx[2:0]]) begin
        if (!g1_v) begin
          g1_v = 1'b1;
          g1   = idx[2:0];
        end else if (!g2_v) begin
          g2_v = 1'b1;
          g2   = idx[2:0];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (g1_v) grant[g1] = 1'b1;
    if (g2_v) grant[g2] = 1'b1;
  end

  assign last      = g2_v ? g2 : g1;
  assign req_ready = ~slot_valid | grant;
  assign accept    = req_valid & req_ready;

  // Squashed incoming results still complete the handshake,
  // they just never become valid in the slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_valid[i] <= !in_kill[i];
        end else if (grant[i] || kill[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_data[i]   <= req_data[i*DATA_W +: DATA_W];
        slot_tag[i]    <= req_tag[i*TW +: TW];
        slot_rob[i]    <= req_rob_idx[i*RW +: RW];
        slot_taken[i]  <= req_branch_taken[i];
        slot_thread[i] <= req_thread[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (g1_v) begin
      rr_ptr <= (last == 3'(NUM_REQ - 1)) ? 3'd0
                                          : last + 3'd1;
    end
  end

  // Unused lanes drive all-zero fields, not stale payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb1_valid           <= 1'b0;
      cdb1_tag             <= '0;
      cdb1_out             <= '0;
      cdb1_rob_idx         <= '0;
      cdb1_branch_is_taken <= 1'b0;
      cdb1_thread          <= 1'b0;
      cdb1_src             <= '0;
      cdb2_valid           <= 1'b0;
      cdb2_tag             <= '0;
      cdb2_out             <= '0;
      cdb2_rob_idx         <= '0;
      cdb2_branch_is_taken <= 1'b0;
      cdb2_thread          <= 1'b0;
      cdb2_src             <= '0;
    end else begin
      cdb1_valid           <= g1_v;
      cdb1_tag             <= g1_v ? slot_tag[g1] : '0;
      cdb1_out             <= g1_v ? slot_data[g1] : '0;
      cdb1_rob_idx         <= g1_v ? slot_rob[g1] : '0;
      cdb1_branch_is_taken <= g1_v & slot_taken[g1];
      cdb1_thread          <= g1_v & slot_thread[g1];
      cdb1_src             <= g1_v ? g1 : '0;
      cdb2_valid           <= g2_v;
      cdb2_tag             <= g2_v ? slot_tag[g2] : '0;
      cdb2_out             <= g2_v ? slot_data[g2] : '0;
      cdb2_rob_idx         <= g2_v ? slot_rob[g2] : '0;
      cdb2_branch_is_taken <= g2_v & slot_taken[g2];
      cdb2_thread          <= g2_v & slot_thread[g2];
      cdb2_src             <= g2_v ? g2 : '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter.
// Scenario tasks run in sequence from one initial block.
module tb_cdb_arbiter;
  localparam int N  = 6;
  localparam int DW = 64;
  localparam int TW = 6;
  localparam int RW = 6;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [N*RW-1:0] req_rob_idx;
  logic [N-1:0]    req_branch_taken;
  logic [N-1:0]    req_thread;
  logic [N-1:0]    req_ready;
  logic squash_thread0;
  logic squash_thread1;
  logic cdb1_valid, cdb2_valid;
  logic [TW-1:0] cdb1_tag, cdb2_tag;
  logic [DW-1:0] cdb1_out, cdb2_out;
  logic [RW-1:0] cdb1_rob_idx, cdb2_rob_idx;
  logic cdb1_branch_is_taken, cdb2_branch_is_taken;
  logic cdb1_thread, cdb2_thread;
  logic [2:0] cdb1_src, cdb2_src;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_tag(req_tag),
    .req_rob_idx(req_rob_idx),
    .req_branch_taken(req_branch_taken),
    .req_thread(req_thread),
    .req_ready(req_ready),
    .squash_thread0(squash_thread0),
    .squash_thread1(squash_thread1),
    .cdb1_valid(cdb1_valid),
    .cdb2_valid(cdb2_valid),
    .cdb1_tag(cdb1_tag),
    .cdb2_tag(cdb2_tag),
    .cdb1_out(cdb1_out),
    .cdb2_out(cdb2_out),
    .cdb1_rob_idx(cdb1_rob_idx),
    .cdb2_rob_idx(cdb2_rob_idx),
    .cdb1_branch_is_taken(cdb1_branch_is_taken),
    .cdb2_branch_is_taken(cdb2_branch_is_taken),
    .cdb1_thread(cdb1_thread),
    .cdb2_thread(cdb2_thread),
    .cdb1_src(cdb1_src),
    .cdb2_src(cdb2_src)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    req_valid        = '0;
    req_data         = '0;
    req_tag          = '0;
    req_rob_idx      = '0;
    req_branch_taken = '0;
    req_thread       = '0;
    squash_thread0   = 1'b0;
    squash_thread1   = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] d,
                         input logic [TW-1:0] t, input logic [RW-1:0] r,
                         input logic tk, input logic th);
    req_valid[i]            = 1'b1;
    req_data[i*DW +: DW]    = d;
    req_tag[i*TW +: TW]     = t;
    req_rob_idx[i*RW +: RW] = r;
    req_branch_taken[i]     = tk;
    req_thread[i]           = th;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 6'h3f) begin errors++; $display("FAIL rst_ready got %b want 111111", req_ready); end
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL rst_cdb1_valid got %b want 0", cdb1_valid); end
    checks++; if (cdb2_valid !== 1'b0) begin errors++; $display("FAIL rst_cdb2_valid got %b want 0", cdb2_valid); end
    checks++; if (cdb1_out !== 64'd0) begin errors++; $display("FAIL rst_cdb1_out got %0d want 0", cdb1_out); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL rst_rr_ptr got %0d want 0", dut.rr_ptr); end
  endtask

  task automatic test_two_sources();
    do_reset();
    set_src(0, 64'd5, 6'd1, 6'b000101, 1'b1, 1'b0);
    set_src(4, 64'd7, 6'd2, 6'd1, 1'b0, 1'b0);
    step();
    clear_in();
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL two_early_valid got %b want 0", cdb1_valid); end
    step();
    checks++; if (cdb1_valid !== 1'b1) begin errors++; $display("FAIL two_cdb1_valid got %b want 1", cdb1_valid); end
    checks++; if (cdb1_tag !== 6'd1) begin errors++; $display("FAIL two_cdb1_tag got %0d want 1", cdb1_tag); end
    checks++; if (cdb1_out !== 64'd5) begin errors++; $display("FAIL two_cdb1_out got %0d want 5", cdb1_out); end
    checks++; if (cdb1_rob_idx !== 6'd5) begin errors++; $display("FAIL two_cdb1_rob got %0d want 5", cdb1_rob_idx); end
    checks++; if (cdb1_branch_is_taken !== 1'b1) begin errors++; $display("FAIL two_cdb1_taken got %b want 1", cdb1_branch_is_taken); end
    checks++; if (cdb1_src !== 3'd0) begin errors++; $display("FAIL two_cdb1_src got %0d want 0", cdb1_src); end
    checks++; if (cdb2_valid !== 1'b1) begin errors++; $display("FAIL two_cdb2_valid got %b want 1", cdb2_valid); end
    checks++; if (cdb2_tag !== 6'd2) begin errors++; $display("FAIL two_cdb2_tag got %0d want 2", cdb2_tag); end
    checks++; if (cdb2_out !== 64'd7) begin errors++; $display("FAIL two_cdb2_out got %0d want 7", cdb2_out); end
    checks++; if (cdb2_rob_idx !== 6'd1) begin errors++; $display("FAIL two_cdb2_rob got %0d want 1", cdb2_rob_idx); end
    checks++; if (cdb2_branch_is_taken !== 1'b0) begin errors++; $display("FAIL two_cdb2_taken got %b want 0", cdb2_branch_is_taken); end
    checks++; if (cdb2_src !== 3'd4) begin errors++; $display("FAIL two_cdb2_src got %0d want 4", cdb2_src); end
    checks++; if (dut.rr_ptr !== 3'd5) begin errors++; $display("FAIL two_rr_ptr got %0d want 5", dut.rr_ptr); end
    step();
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL two_once got %b want 0", cdb1_valid); end
    checks++; if (cdb1_tag !== 6'd0) begin errors++; $display("FAIL two_idle_tag got %0d want 0", cdb1_tag); end
  endtask

  task automatic test_all_six();
    logic [5:0] rdy_exp [3] = '{6'b000011, 6'b001111, 6'b111111};
    int s1 [3] = '{0, 2, 4};
    do_reset();
    for (int i = 0; i < N; i++)
      set_src(i, 64'(100 + i), 6'(10 + i), 6'(i), 1'b0, 1'b0);
    step();
    clear_in();
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_ready !== rdy_exp[c]) begin errors++; $display("FAIL six_ready[%0d] got %b want %b", c, req_ready, rdy_exp[c]); end
      step();
      checks++; if (cdb1_src !== 3'(s1[c])) begin errors++; $display("FAIL six_cdb1_src[%0d] got %0d want %0d", c, cdb1_src, s1[c]); end
      checks++; if (cdb2_src !== 3'(s1[c] + 1)) begin errors++; $display("FAIL six_cdb2_src[%0d] got %0d want %0d", c, cdb2_src, s1[c] + 1); end
      checks++; if (cdb1_out !== 64'(100 + s1[c])) begin errors++; $display("FAIL six_cdb1_out[%0d] got %0d want %0d", c, cdb1_out, 100 + s1[c]); end
      checks++; if (cdb2_tag !== 6'(11 + s1[c])) begin errors++; $display("FAIL six_cdb2_tag[%0d] got %0d want %0d", c, cdb2_tag, 11 + s1[c]); end
    end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL six_rr_ptr got %0d want 0", dut.rr_ptr); end
    step();
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL six_drain got %b want 0", cdb1_valid); end
  endtask

  task automatic test_rotation();
    int e1s [4] = '{0, 2, 1, 0};
    int e1q [4] = '{0, 0, 1, 2};
    int e2s [4] = '{1, 0, 2, 1};
    int e2q [4] = '{0, 1, 1, 2};
    int seq [3];
    logic [N-1:0] rdy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0;
      set_src(i, 64'(16 * i), 6'(20 + i), 6'(i), 1'b0, 1'b0);
    end
    for (int c = -1; c < 4; c++) begin
      rdy = req_ready;
      step();
      for (int i = 0; i < 3; i++)
        if (rdy[i]) begin
          seq[i]++;
          req_data[i*DW +: DW] = 64'(16 * i + seq[i]);
        end
      if (c < 0) begin
        checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL rot_first got %b want 0", cdb1_valid); end
      end else begin
        checks++; if (cdb1_src !== 3'(e1s[c])) begin errors++; $display("FAIL rot_cdb1_src[%0d] got %0d want %0d", c, cdb1_src, e1s[c]); end
        checks++; if (cdb2_src !== 3'(e2s[c])) begin errors++; $display("FAIL rot_cdb2_src[%0d] got %0d want %0d", c, cdb2_src, e2s[c]); end
        checks++; if (cdb1_out !== 64'(16 * e1s[c] + e1q[c])) begin errors++; $display("FAIL rot_cdb1_out[%0d] got %0d want %0d", c, cdb1_out, 16 * e1s[c] + e1q[c]); end
        checks++; if (cdb2_out !== 64'(16 * e2s[c] + e2q[c])) begin errors++; $display("FAIL rot_cdb2_out[%0d] got %0d want %0d", c, cdb2_out, 16 * e2s[c] + e2q[c]); end
      end
    end
    clear_in();
  endtask

  task automatic test_squash();
    do_reset();
    set_src(1, 64'd55, 6'd11, 6'd3, 1'b0, 1'b0);
    set_src(3, 64'd66, 6'd13, 6'd4, 1'b0, 1'b1);
    step();
    clear_in();
    squash_thread1 = 1'b1;
    set_src(5, 64'd77, 6'd15, 6'd7, 1'b0, 1'b1);
    #1;
    checks++; if (req_ready[3] !== 1'b0) begin errors++; $display("FAIL sq_held_ready3 got %b want 0", req_ready[3]); end
    step();
    clear_in();
    checks++; if (cdb1_valid !== 1'b1) begin errors++; $display("FAIL sq_cdb1_valid got %b want 1", cdb1_valid); end
    checks++; if (cdb1_tag !== 6'd11) begin errors++; $display("FAIL sq_cdb1_tag got %0d want 11", cdb1_tag); end
    checks++; if (cdb1_src !== 3'd1) begin errors++; $display("FAIL sq_cdb1_src got %0d want 1", cdb1_src); end
    checks++; if (cdb2_valid !== 1'b0) begin errors++; $display("FAIL sq_cdb2_valid got %b want 0", cdb2_valid); end
    checks++; if (req_ready[3] !== 1'b1) begin errors++; $display("FAIL sq_ready3 got %b want 1", req_ready[3]); end
    checks++; if (dut.slot_valid[3] !== 1'b0) begin errors++; $display("FAIL sq_slot3 got %b want 0", dut.slot_valid[3]); end
    step();
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL sq_dropped got %b want 0", cdb1_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++)
      set_src(i, 64'(200 + i), 6'(40 + i), 6'(i), 1'b0, 1'b0);
    step();
    clear_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL mid_cdb1_valid got %b want 0", cdb1_valid); end
    checks++; if (cdb2_valid !== 1'b0) begin errors++; $display("FAIL mid_cdb2_valid got %b want 0", cdb2_valid); end
    checks++; if (req_ready !== 6'h3f) begin errors++; $display("FAIL mid_ready got %b want 111111", req_ready); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL mid_rr_ptr got %0d want 0", dut.rr_ptr); end
    step();
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL mid_after got %b want 0", cdb1_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_src(5, 64'(k + 1), 6'd30, 6'd9, 1'b0, 1'b0);
      checks++; if (req_ready[5] !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", k, req_ready[5]); end
      step();
      if (k > 0) begin
        checks++; if (cdb1_out !== 64'(k)) begin errors++; $display("FAIL b2b_out[%0d] got %0d want %0d", k, cdb1_out, k); end
        checks++; if (cdb1_src !== 3'd5) begin errors++; $display("FAIL b2b_src[%0d] got %0d want 5", k, cdb1_src); end
      end
    end
    clear_in();
    step();
    checks++; if (cdb1_out !== 64'd4) begin errors++; $display("FAIL b2b_out_last got %0d want 4", cdb1_out); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL b2b_rr_ptr got %0d want 0", dut.rr_ptr); end
    step();
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", cdb1_valid); end
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_two_sources();
    test_all_six();
    test_rotation();
    test_squash();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
